// File: rtl/dv_seq_pkg.sv
// dv_seq_pkg: shared types for the DV test-phase sequencer.
// Phase states, fail_code width and fail_code values.
package dv_seq_pkg;

  localparam int FCW = 2;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    WAIT_ACT,
    RUN,
    DRAIN,
    END
  } state_t;

  localparam logic [FCW-1:0] FC_NONE   = 2'd0;
  localparam logic [FCW-1:0] FC_ACTIVE = 2'd1;
  localparam logic [FCW-1:0] FC_TEST   = 2'd2;
  localparam logic [FCW-1:0] FC_DRAIN  = 2'd3;

endpackage

// File: rtl/dv_seq_watchdog.sv
// dv_seq_watchdog: saturating phase counter shared by all phases.
// expired is high while the count sits at limit-1.
module dv_seq_watchdog #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  // count up while enabled, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != '1) begin
      cnt <= cnt + ONE;
    end
  end

  assign expired = (cnt == limit - ONE);

endmodule

// File: rtl/dv_test_sequencer.sv
// dv_test_sequencer: reset/wait/run/drain controller with watchdogs.
// Optional run_cycles output enabled by DV_SEQ_CYCLE_COUNT_EN.
module dv_test_sequencer
  import dv_seq_pkg::*;
#(
  parameter int RESET_CYCLES   = 20,
  parameter int ACTIVE_TIMEOUT = 1000,
  parameter int TEST_TIMEOUT   = 10000,
  parameter int DRAIN_CYCLES   = 16,
  parameter int CW             = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic           dut_active,
  input  logic           stim_done,
  input  logic           test_done,
  output logic           dut_nreset,
  output logic           start,
  output logic           busy,
  output logic           finish,
  output logic           pass,
  output logic           fail,
  output logic [FCW-1:0] fail_code
`ifdef DV_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]    run_cycles
`endif
);

  localparam logic [CW-1:0] L_RST   = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] L_ACT   = CW'(ACTIVE_TIMEOUT);
  localparam logic [CW-1:0] L_TEST  = CW'(TEST_TIMEOUT);
  localparam logic [CW-1:0] L_DRAIN = CW'(DRAIN_CYCLES);

  state_t          state;
  state_t          nxt;
  logic            ok;
  logic [FCW-1:0]  code;
  logic [CW-1:0]   limit;
  logic            wd_exp;
  logic            wd_clear;
  logic            wd_en;
  logic            entering_end;
  logic            leaving_idle;

  // next phase; success is tested before the watchdog so it wins ties
  always_comb begin
    nxt  = state;
    ok   = 1'b0;
    code = FC_NONE;
    unique case (state)
      IDLE: begin
        if (go) nxt = RST;
      end
      RST: begin
        if (wd_exp) nxt = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (dut_active) begin
          nxt = RUN;
        end else if (wd_exp) begin
          nxt  = END;
          code = FC_ACTIVE;
        end
      end
      RUN: begin
        if (stim_done && test_done) begin
          nxt = END;
          ok  = 1'b1;
        end else if (stim_done) begin
          nxt = DRAIN;
        end else if (wd_exp) begin
          nxt  = END;
          code = FC_TEST;
        end
      end
      DRAIN: begin
        if (test_done) begin
          nxt = END;
          ok  = 1'b1;
        end else if (wd_exp) begin
          nxt  = END;
          code = FC_DRAIN;
        end
      end
      END: begin
        if (!go) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // watchdog limit for the phase currently active
  always_comb begin
    limit = L_RST;
    unique case (state)
      WAIT_ACT: limit = L_ACT;
      RUN:      limit = L_TEST;
      DRAIN:    limit = L_DRAIN;
      default:  limit = L_RST;
    endcase
  end

  assign wd_clear     = reset || (nxt != state);
  assign wd_en        = (state != IDLE) && (state != END);
  assign entering_end = (nxt == END) && (state != END);
  assign leaving_idle = (state == IDLE) && (nxt == RST);

  dv_seq_watchdog #(
    .CW(CW)
  ) u_wd (
    .clk     (clk),
    .clear   (wd_clear),
    .enable  (wd_en),
    .limit   (limit),
    .expired (wd_exp)
  );

  // phase register and registered outputs decoded from the next phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dut_nreset <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_code  <= FC_NONE;
    end else begin
      state      <= nxt;
      dut_nreset <= (nxt == WAIT_ACT) || (nxt == RUN) ||
                    (nxt == DRAIN) || (nxt == END);
      start      <= (nxt == RUN) || (nxt == DRAIN);
      busy       <= (nxt != IDLE) && (nxt != END);
      finish     <= entering_end;
      if (leaving_idle) begin
        pass      <= 1'b0;
        fail      <= 1'b0;
        fail_code <= FC_NONE;
      end else if (entering_end) begin
        pass      <= ok;
        fail      <= !ok;
        fail_code <= code;
      end
    end
  end

`ifdef DV_SEQ_CYCLE_COUNT_EN
  // cycles spent in RUN+DRAIN, cleared on a new sequence, saturating
  always_ff @(posedge clk) begin
    if (reset || leaving_idle) begin
      run_cycles <= '0;
    end else if ((state == RUN || state == DRAIN) &&
                 run_cycles != 32'hFFFF_FFFF) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dv_test_sequencer.sv
// tb_dv_test_sequencer: directed and randomized phase scenarios.
// Expected event cycles come from an arithmetic phase model.
module tb_dv_test_sequencer;

  localparam int RC = 20;
  localparam int AT = 50;
  localparam int TT = 100;
  localparam int DC = 16;

  logic clk = 1'b0;
  logic reset;
  logic go;
  logic dut_active;
  logic stim_done;
  logic test_done;
  logic dut_nreset;
  logic start;
  logic busy;
  logic finish;
  logic pass;
  logic fail;
  logic [1:0] fail_code;
`ifdef DV_SEQ_CYCLE_COUNT_EN
  logic [31:0] run_cycles;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dv_test_sequencer #(
    .RESET_CYCLES   (RC),
    .ACTIVE_TIMEOUT (AT),
    .TEST_TIMEOUT   (TT),
    .DRAIN_CYCLES   (DC),
    .CW             (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .dut_active (dut_active),
    .stim_done  (stim_done),
    .test_done  (test_done),
    .dut_nreset (dut_nreset),
    .start      (start),
    .busy       (busy),
    .finish     (finish),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code)
`ifdef DV_SEQ_CYCLE_COUNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  task automatic test_reset();
    reset = 1'b1;
    go = 1'b1;
    dut_active = 1'b0;
    stim_done = 1'b0;
    test_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({dut_nreset, start, busy, finish, pass, fail, fail_code} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 00000000",
               {dut_nreset, start, busy, finish, pass, fail, fail_code});
    end
    go = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || dut_nreset !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b nreset=%b want 0 0",
               busy, dut_nreset);
    end
  endtask

  // a: dut_active offset from WAIT_ACT entry; s/t: stim/test offsets from RUN entry
  task automatic run_case(input int a, input int s, input int t, input string nm);
    int g, w, r, e, code, n, exp_rc;
    bit ran, both;
    int nr_rise, st_rise, fin_n, fin_at;
    logic p_got, f_got, busy_w, idle_nr, idle_busy, idle_pass;
    logic [1:0] c_got;
    logic [31:0] rc_got, rc_late;
    g = cyc + 3;
    w = g + RC;
    r = 0;
    ran = 0;
    if (a <= AT) begin
      ran = 1;
      r = w + a;
      if (s <= TT) begin
        if (t <= s) begin
          e = r + s; code = 0;
        end else if (t - s <= DC) begin
          e = r + t; code = 0;
        end else begin
          e = r + s + DC; code = 3;
        end
      end else begin
        e = r + TT; code = 2;
      end
    end else begin
      e = w + AT; code = 1;
    end
    exp_rc = ran ? e - r : 0;
    both = 0;
    nr_rise = -1; st_rise = -1; fin_n = 0; fin_at = -1;
    p_got = 'x; f_got = 'x; c_got = 'x; busy_w = 'x;
    idle_nr = 'x; idle_busy = 'x; idle_pass = 'x;
    rc_got = 'x; rc_late = 'x;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (dut_nreset === 1'b1 && nr_rise < 0) nr_rise = cyc;
      if (start === 1'b1 && st_rise < 0) st_rise = cyc;
      if (finish === 1'b1) begin
        fin_n++;
        fin_at = cyc;
        p_got = pass;
        f_got = fail;
        c_got = fail_code;
`ifdef DV_SEQ_CYCLE_COUNT_EN
        rc_got = run_cycles;
`endif
      end
      if (pass === 1'b1 && fail === 1'b1) both = 1;
      if (cyc == w) busy_w = busy;
      if (cyc == e + 1) begin
        idle_nr = dut_nreset;
        idle_busy = busy;
        idle_pass = pass;
`ifdef DV_SEQ_CYCLE_COUNT_EN
        rc_late = run_cycles;
`endif
      end
      if (cyc >= e + 3) break;
      n = cyc + 1;
      go = (n >= g && n < g + 3);
      dut_active = (n >= w + a && n < w + a + 3);
      stim_done = ran && (n >= r + s) && (n < r + s + 2);
      test_done = ran && (n >= r + t);
    end
    go = 1'b0;
    dut_active = 1'b0;
    stim_done = 1'b0;
    test_done = 1'b0;
    n_checks++;
    if (nr_rise != w) begin
      n_fail++;
      $display("FAIL %s nreset_rise got %0d want %0d", nm, nr_rise, w);
    end
    n_checks++;
    if (st_rise != (ran ? r : -1)) begin
      n_fail++;
      $display("FAIL %s start_rise got %0d want %0d", nm, st_rise, ran ? r : -1);
    end
    n_checks++;
    if (fin_n != 1 || fin_at != e) begin
      n_fail++;
      $display("FAIL %s finish pulses=%0d at %0d want 1 at %0d", nm, fin_n, fin_at, e);
    end
    n_checks++;
    if (p_got !== (code == 0) || f_got !== (code != 0) || c_got !== 2'(code)) begin
      n_fail++;
      $display("FAIL %s result pass=%b fail=%b code=%0d want %b %b %0d",
               nm, p_got, f_got, c_got, code == 0, code != 0, code);
    end
    n_checks++;
    if (both) begin
      n_fail++;
      $display("FAIL %s pass_and_fail got both want exclusive", nm);
    end
    n_checks++;
    if (busy_w !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_at_wait got %b want 1", nm, busy_w);
    end
    n_checks++;
    if (idle_nr !== 1'b0 || idle_busy !== 1'b0 || idle_pass !== (code == 0)) begin
      n_fail++;
      $display("FAIL %s back_to_idle nreset=%b busy=%b pass=%b want 0 0 %b",
               nm, idle_nr, idle_busy, idle_pass, code == 0);
    end
`ifdef DV_SEQ_CYCLE_COUNT_EN
    n_checks++;
    if (rc_got !== 32'(exp_rc) || rc_late !== 32'(exp_rc)) begin
      n_fail++;
      $display("FAIL %s run_cycles got %0d/%0d want %0d", nm, rc_got, rc_late, exp_rc);
    end
`endif
  endtask

  task automatic test_nominal();
    run_case(15, 60, 60, "nominal");
  endtask

  task automatic test_active_timeout();
    run_case(1000, 1, 1, "active_timeout");
  endtask

  task automatic test_drain();
    run_case(5, 20, 30, "drain_pass");
    run_case(5, 20, 300, "drain_timeout");
    run_case(5, 20, 20 + DC, "drain_edge_pass");
    run_case(5, 20, 21 + DC, "drain_edge_fail");
  endtask

  task automatic test_race();
    run_case(AT, TT, TT, "race_success_wins");
    run_case(1, TT + 1, TT + 1, "test_timeout");
    run_case(1, TT, TT + 1, "race_into_drain");
  endtask

  task automatic test_mid_reset();
    int k;
    go = 1'b1;
    k = 0;
    while (start !== 1'b1 && k < 200) begin
      @(negedge clk);
      dut_active = dut_nreset;
      k++;
    end
    n_checks++;
    if (start !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_reach_run start=%b want 1", start);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({dut_nreset, start, busy, finish, pass, fail, fail_code} !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %b want 00000000",
               {dut_nreset, start, busy, finish, pass, fail, fail_code});
    end
    go = 1'b0;
    dut_active = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || dut_nreset !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle busy=%b nreset=%b want 0 0", busy, dut_nreset);
    end
    run_case(3, 10, 12, "restart_after_reset");
  endtask

  task automatic test_random();
    int a, s, t;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(AT + 3, 1);
      s = $urandom_range(TT + 3, 1);
      t = $urandom_range(s + DC + 4, 1);
      run_case(a, s, t, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    reset = 1'b1;
    go = 1'b0;
    dut_active = 1'b0;
    stim_done = 1'b0;
    test_done = 1'b0;
    test_reset();
    test_nominal();
    test_active_timeout();
    test_drain();
    test_race();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dv_test_sequencer.md
Name: dv_test_sequencer

Overview:
- Synthesizable, cycle-accurate test-phase controller for the DV harness.
- Sequences the DUT through reset hold, wait-for-active, run and drain phases, with watchdogs on each phase.
- Reports pass or fail plus a one-cycle finish pulse, so benches (including Verilator builds) end deterministically instead of via a blind delay.
- Sits between the clock/reset source and the DUT/stimulus blocks.

Parameters:
- RESET_CYCLES, 20, cycles dut_nreset is held low (must be >= 1).
- ACTIVE_TIMEOUT, 1000, max cycles in WAIT_ACT before fail.
- TEST_TIMEOUT, 10000, max cycles in RUN before fail.
- DRAIN_CYCLES, 16, max cycles in DRAIN waiting for test_done.
- CW, 32, width of internal phase counter; must hold the largest timeout.

Ports:
- clk  in  1  main clock
- reset  in  1  synchronous, active-high reset
- go  in  1  level; rising into IDLE starts a sequence
- dut_active  in  1  DUT reports reset sequence complete
- stim_done  in  1  stimulus finished (level)
- test_done  in  1  checker finished (level)
- dut_nreset  out  1  active-low reset driven to DUT
- start  out  1  level; test running
- busy  out  1  high in every state except IDLE/END
- finish  out  1  one-cycle pulse on entry to END
- pass  out  1  sticky success
- fail  out  1  sticky failure
- fail_code  out  2  0 none, 1 active timeout, 2 test timeout, 3 drain timeout

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on port reset, sampled on posedge clk.
- All outputs are registered. Reset values:
  - state=IDLE, dut_nreset=0, start=0, busy=0, finish=0, pass=0, fail=0, fail_code=0.
  - Phase counter cleared.
- IDLE:
  - dut_nreset=0.
  - go=1 -> RST; counter=0; pass/fail/fail_code cleared on this transition.
- RST:
  - dut_nreset=0 for exactly RESET_CYCLES cycles after IDLE exit.
  - Then dut_nreset=1 on the same edge as entry to WAIT_ACT; counter cleared.
- WAIT_ACT:
  - dut_active=1 -> RUN; start=1 from the next edge.
  - counter==ACTIVE_TIMEOUT-1 without dut_active -> END, fail=1, code 1.
- RUN:
  - start held 1.
  - stim_done & test_done -> END, pass=1.
  - stim_done alone -> DRAIN, counter cleared.
  - counter==TEST_TIMEOUT-1 -> END, fail=1, code 2.
- DRAIN:
  - test_done -> END, pass=1.
  - counter==DRAIN_CYCLES-1 -> END, fail=1, code 3.
  - stim_done dropping in DRAIN is ignored.
- END:
  - start=0, busy=0, dut_nreset stays 1.
  - finish=1 only on the entry cycle.
  - pass/fail held. go=0 -> IDLE, with pass/fail still held.
- Simultaneous events:
  - A success condition and watchdog expiry in the same cycle -> success wins.
  - pass and fail are never both 1.
- dut_active deasserting during RUN/DRAIN is ignored.
- go deasserted mid-sequence has no effect until END.
- reset mid-operation: immediate return to reset values on the next edge, from any state. dut_nreset goes low that edge.
- Counter saturates at all-ones; it never wraps.

Optional Feature:
- Macro: DV_SEQ_CYCLE_COUNT_EN.
- Defined:
  - Adds output run_cycles[31:0], counting clk cycles spent in RUN+DRAIN.
  - Cleared on IDLE->RST, frozen in END, saturating at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package dv_seq_pkg holds:
  - State enum: IDLE, RST, WAIT_ACT, RUN, DRAIN, END.
  - fail_code constants: FC_NONE, FC_ACTIVE, FC_TEST, FC_DRAIN.
  - Width constant for fail_code.
- Sub-module dv_seq_watchdog:
  - Ports: clear, enable, limit input; expired flag output.
  - Saturating up-counter of width CW.
  - Instantiated once and reloaded per phase.

Test Plan:
- Nominal run:
  - Stimulus: RESET_CYCLES=20; go=1 at cycle 5; dut_active=1 at cycle 40; stim_done=test_done=1 at cycle 100.
  - Response: dut_nreset rises exactly 20 cycles after IDLE exit; start rises one cycle after dut_active; pass=1, fail_code=0, single finish pulse.
- Active timeout:
  - Stimulus: ACTIVE_TIMEOUT=50; dut_active held 0.
  - Response: END 50 cycles after WAIT_ACT entry; fail=1, fail_code=1; start never asserted.
- Drain path:
  - Stimulus: stim_done=1 at cycle 200, test_done=1 at cycle 210, DRAIN_CYCLES=16.
  - Response: pass=1. Repeat with test_done withheld -> fail_code=3 after 16 cycles in DRAIN.
- Race:
  - Stimulus: TEST_TIMEOUT=100; stim_done&test_done asserted on the same cycle the watchdog expires.
  - Response: pass=1, fail=0.
- Mid-run reset:
  - Stimulus: assert reset for 1 cycle while in RUN.
  - Response: next edge shows dut_nreset=0, start=0, pass=fail=0, state IDLE. go re-rising restarts the sequence cleanly.
- Optional feature (with DV_SEQ_CYCLE_COUNT_EN):
  - Stimulus: nominal run with 60 cycles spent in RUN+DRAIN.
  - Response: run_cycles=60, frozen after finish.
